// File: rtl/pcoeff_result_collector.sv
// Drains per-batch pcoeff results from the upstream FIFO and sums them into one total per top.
// Optional stall counter output enabled by defining PCOEFF_COLLECTOR_STALL_COUNTER_EN.
module pcoeff_result_collector #(
  parameter int COUNT_W   = 35,
  parameter int SUM_W     = 70,
  parameter int BATCHES_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         startTop,
  input  logic [BATCHES_W-1:0]         batchesExpected,
  input  logic                         resultsAvailable,
  output logic                         grabResults,
  input  logic [SUM_W-1:0]             pcoeffSumIn,
  input  logic [COUNT_W-1:0]           pcoeffCountIn,
  output logic                         totalValid,
  input  logic                         totalReady,
  output logic [SUM_W+BATCHES_W-1:0]   totalSum,
  output logic [COUNT_W+BATCHES_W-1:0] totalCount,
  output logic                         busy
`ifdef PCOEFF_COLLECTOR_STALL_COUNTER_EN
  ,
  output logic [31:0]                  stallCycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                        state_reg;
  logic [BATCHES_W-1:0]          expected_reg;
  logic [BATCHES_W-1:0]          issued_reg;
  logic [BATCHES_W-1:0]          received_reg;
  logic                          grab_d_reg;
  logic [SUM_W+BATCHES_W-1:0]    sum_reg;
  logic [COUNT_W+BATCHES_W-1:0]  count_reg;
  logic                          valid_reg;
  logic                          grab_next;
  logic [BATCHES_W-1:0]          received_next;

  // Grab is gated by the issued count so the next top's results stay in the FIFO.
  assign grab_next     = (state_reg == COLLECT) && resultsAvailable && (issued_reg != expected_reg);
  assign received_next = received_reg + 1'b1;

  assign grabResults = grab_next;
  assign totalValid  = valid_reg;
  assign totalSum    = sum_reg;
  assign totalCount  = count_reg;
  assign busy        = (state_reg != IDLE);

`ifdef PCOEFF_COLLECTOR_STALL_COUNTER_EN
  logic [31:0] stall_reg;
  assign stallCycles = stall_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (startTop) stall_reg <= '0;
    end else if (state_reg == COLLECT) begin
      if (!grab_next && (received_reg != expected_reg) && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      expected_reg <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      grab_d_reg   <= 1'b0;
      sum_reg      <= '0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
    end else begin
      // FIFO read latency is one cycle, so data pairs with the delayed strobe.
      grab_d_reg <= grab_next;
      case (state_reg)
        IDLE: begin
          if (startTop) begin
            expected_reg <= batchesExpected;
            issued_reg   <= '0;
            received_reg <= '0;
            sum_reg      <= '0;
            count_reg    <= '0;
            if (batchesExpected == '0) begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (grab_next) issued_reg <= issued_reg + 1'b1;
          if (grab_d_reg) begin
            sum_reg      <= sum_reg + {{BATCHES_W{1'b0}}, pcoeffSumIn};
            count_reg    <= count_reg + {{BATCHES_W{1'b0}}, pcoeffCountIn};
            received_reg <= received_next;
            if (received_next == expected_reg) begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (valid_reg && totalReady) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Scoreboard bench for pcoeff_result_collector with a one-cycle-latency FIFO model.
// Stall counter checks are compiled in when PCOEFF_COLLECTOR_STALL_COUNTER_EN is defined.
module tb_pcoeff_result_collector;
  localparam int COUNT_W   = 35;
  localparam int SUM_W     = 70;
  localparam int BATCHES_W = 16;
  localparam int TS_W      = SUM_W + BATCHES_W;
  localparam int TC_W      = COUNT_W + BATCHES_W;

  typedef struct {
    logic [SUM_W-1:0]   s;
    logic [COUNT_W-1:0] c;
  } ent_t;
  typedef struct {
    logic [TS_W-1:0] s;
    logic [TC_W-1:0] c;
  } tot_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 startTop = 1'b0;
  logic [BATCHES_W-1:0] batchesExpected = '0;
  logic                 resultsAvailable;
  logic                 grabResults;
  logic [SUM_W-1:0]     pcoeffSumIn = '0;
  logic [COUNT_W-1:0]   pcoeffCountIn = '0;
  logic                 totalValid;
  logic                 totalReady = 1'b0;
  logic [TS_W-1:0]      totalSum;
  logic [TC_W-1:0]      totalCount;
  logic                 busy;
`ifdef PCOEFF_COLLECTOR_STALL_COUNTER_EN
  logic [31:0]          stallCycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int grab_count = 0;
  int fifo_cnt = 0;
  logic ra_enable = 1'b1;
  ent_t fifo_q[$];
  tot_t exp_q[$];

  always #5 clk = ~clk;

  assign resultsAvailable = ra_enable && (fifo_cnt > 0);

  pcoeff_result_collector #(.COUNT_W(COUNT_W), .SUM_W(SUM_W), .BATCHES_W(BATCHES_W)) dut (
    .clk(clk), .rst(rst), .startTop(startTop), .batchesExpected(batchesExpected),
    .resultsAvailable(resultsAvailable), .grabResults(grabResults),
    .pcoeffSumIn(pcoeffSumIn), .pcoeffCountIn(pcoeffCountIn),
    .totalValid(totalValid), .totalReady(totalReady),
    .totalSum(totalSum), .totalCount(totalCount), .busy(busy)
`ifdef PCOEFF_COLLECTOR_STALL_COUNTER_EN
    , .stallCycles(stallCycles)
`endif
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Upstream FIFO: read strobe sampled at the edge, data appears after that edge.
  always @(posedge clk) begin
    ent_t e;
    if (grabResults) begin
      grab_count++;
      if (fifo_q.size() > 0) begin
        e = fifo_q.pop_front();
        pcoeffSumIn   <= e.s;
        pcoeffCountIn <= e.c;
      end else begin
        n_checks++;
        n_fails++;
        $display("FAIL fifo_underflow: grab with empty FIFO");
      end
    end
    fifo_cnt <= fifo_q.size();
  end

  // Monitor: pop expected total on each rising totalValid, then require stability.
  logic prev_valid = 1'b0;
  tot_t held;
  always @(negedge clk) begin
    tot_t ex;
    if (totalValid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_total: sum %0d count %0d", totalSum, totalCount);
        end else begin
          ex = exp_q.pop_front();
          check("total_sum", 128'(totalSum), 128'(ex.s));
          check("total_count", 128'(totalCount), 128'(ex.c));
        end
        held.s = totalSum;
        held.c = totalCount;
      end else begin
        check("hold_sum", 128'(totalSum), 128'(held.s));
        check("hold_count", 128'(totalCount), 128'(held.c));
      end
    end
    prev_valid = totalValid;
  end

  task automatic push_ent(input logic [SUM_W-1:0] s, input logic [COUNT_W-1:0] c);
    ent_t e;
    e.s = s;
    e.c = c;
    fifo_q.push_back(e);
  endtask

  task automatic push_exp(input logic [TS_W-1:0] s, input logic [TC_W-1:0] c);
    tot_t t;
    t.s = s;
    t.c = c;
    exp_q.push_back(t);
  endtask

  task automatic start_top(input int n);
    startTop = 1'b1;
    batchesExpected = BATCHES_W'(n);
    @(posedge clk);
    #1;
    startTop = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (totalValid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_valid: totalValid not seen within %0d cycles", budget);
    end
  endtask

  task automatic accept();
    totalReady = 1'b1;
    @(posedge clk);
    #1;
    totalReady = 1'b0;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_valid", 128'(totalValid), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TS_W-1:0] big_s;
    logic [TC_W-1:0] big_c;
    int g0;

    // Reset with resultsAvailable high and data present.
    push_ent(70'd9, 35'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_grab", 128'(grabResults), 128'(0));
      check("rst_valid", 128'(totalValid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_reads", 128'(grab_count), 128'(0));
    fifo_q.delete();
    @(negedge clk);

    // Basic collect: 100+250+7=357, 2+5+1=8.
    push_ent(70'd100, 35'd2);
    push_ent(70'd250, 35'd5);
    push_ent(70'd7, 35'd1);
    push_exp(86'd357, 51'd8);
    g0 = grab_count;
    start_top(3);
    wait_valid(20);
    repeat (3) @(negedge clk);
    check("basic_grabs", 128'(grab_count - g0), 128'(3));
    accept();

    // Over-grab guard: 4 entries, two tops of 2.
    push_ent(70'd1, 35'd1);
    push_ent(70'd2, 35'd2);
    push_ent(70'd30, 35'd3);
    push_ent(70'd40, 35'd4);
    push_exp(86'd3, 51'd3);
    push_exp(86'd70, 51'd7);
    g0 = grab_count;
    start_top(2);
    wait_valid(20);
    repeat (4) @(negedge clk);
    check("guard_grabs", 128'(grab_count - g0), 128'(2));
    check("guard_left", 128'(fifo_q.size()), 128'(2));
    accept();
    start_top(2);
    wait_valid(20);
    check("guard2_grabs", 128'(grab_count - g0), 128'(4));
    accept();

    // Zero batches with backpressure.
    push_exp(86'd0, 51'd0);
    g0 = grab_count;
    start_top(0);
    @(negedge clk);
    check("zero_valid_next", 128'(totalValid), 128'(1));
    repeat (10) @(negedge clk);
    check("zero_still_valid", 128'(totalValid), 128'(1));
    check("zero_grabs", 128'(grab_count - g0), 128'(0));
    accept();

`ifdef PCOEFF_COLLECTOR_STALL_COUNTER_EN
    // Stall counter: five stalled cycles with resultsAvailable gated low.
    ra_enable = 1'b0;
    push_ent(70'd5, 35'd5);
    push_exp(86'd5, 51'd5);
    start_top(1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_cycles", 128'(stallCycles), 128'(5));
    ra_enable = 1'b1;
    wait_valid(20);
    accept();
`endif

    // Mid-operation reset after one of three results.
    ra_enable = 1'b0;
    push_ent(70'd11, 35'd1);
    push_ent(70'd22, 35'd2);
    push_ent(70'd33, 35'd3);
    g0 = grab_count;
    start_top(3);
    @(negedge clk);
    ra_enable = 1'b1;
    @(negedge clk);
    ra_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_one_grab", 128'(grab_count - g0), 128'(1));
    check("mid_partial_sum", 128'(totalSum), 128'(11));
    check("mid_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_sum", 128'(totalSum), 128'(0));
    check("mid_rst_count", 128'(totalCount), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    ra_enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_more_grabs", 128'(grab_count - g0), 128'(1));
    check("mid_fifo_left", 128'(fifo_q.size()), 128'(2));
    check("mid_idle_valid", 128'(totalValid), 128'(0));
    fifo_q.delete();
    repeat (2) @(negedge clk);

    // Width: 65535 maximal results, exact totals.
    for (int k = 0; k < 65535; k++) push_ent({SUM_W{1'b1}}, {COUNT_W{1'b1}});
    big_s = TS_W'(65535) * {{BATCHES_W{1'b0}}, {SUM_W{1'b1}}};
    big_c = TC_W'(65535) * {{BATCHES_W{1'b0}}, {COUNT_W{1'b1}}};
    push_exp(big_s, big_c);
    g0 = grab_count;
    start_top(65535);
    wait_valid(70000);
    check("width_grabs", 128'(grab_count - g0), 128'(65535));
    accept();

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
